mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max cycles a memory-port request waits for mem_ack (only used with MEM_ARBITER_TIMEOUT_EN).
REQ-002 SHALL have ports, clock and reset first: clk in 1, single clock; reset in 1, synchronous active-high.
REQ-003 fetch_addr in 32, instruction fetch address from datapath.
REQ-004 fetch_request in 1, fetch wanted.
REQ-005 memory_addr in 32; write_data in 32; write_mask in 4, byte enables; data access from datapath.
REQ-006 memory_request in 1, data access wanted; memory_request_type in 1, 0=load, 1=store.
REQ-007 stall out 1; fetch_data_valid out 1; memory_data_valid out 1; request_data out 32, returned word.
REQ-008 mem_addr out 32; mem_wdata out 32; mem_wmask out 4; mem_we out 1; mem_req out 1, single shared memory port.
REQ-009 mem_ack in 1, one-cycle completion strobe; mem_rdata in 32, valid with mem_ack.
REQ-010 bus_error out 1, one-cycle timeout strobe.

Function
REQ-011 SHALL arbitrate fetch and data accesses onto one memory port with FSM states IDLE, DATA, FETCH.
REQ-012 IDLE: memory_request=1 and data_done=0 -> DATA; else fetch_request=1 -> FETCH; else stay IDLE.
REQ-013 Data access SHALL take priority over fetch, so the executing instruction's load/store completes before the next fetch.
REQ-014 On entering DATA/FETCH, mem_addr/mem_wdata/mem_wmask/mem_we SHALL be registered from datapath inputs and held stable until mem_ack; mem_we=memory_request_type in DATA, 0 in FETCH; mem_wmask=0 in FETCH.
REQ-015 mem_req SHALL be 1 exactly while state is DATA or FETCH; one cycle latency from datapath request to mem_req.
REQ-016 DATA with mem_ack: set data_done; memory_data_valid=1 for that cycle only if load; request_data=mem_rdata; next state IDLE.
REQ-017 FETCH with mem_ack: fetch_data_valid=1, request_data=mem_rdata that cycle; clear data_done; next state IDLE.
REQ-018 stall SHALL be combinational: 0 only in the FETCH-with-mem_ack cycle, 1 otherwise (including IDLE).
REQ-019 request_data SHALL be 0 in cycles without mem_ack.
REQ-020 mem_ack in IDLE SHALL be ignored: no valid strobe, no state change.
REQ-021 data_done SHALL prevent re-issuing the same data access while memory_request stays high during stall.
REQ-022 bus_error SHALL be 0 except as REQ-026.

Reset
REQ-023 reset SHALL force state IDLE, data_done=0, mem_req=0, mem_we=0, mem_addr/mem_wdata=0, mem_wmask=0, timeout counter=0; stall=1, all valid strobes and bus_error=0.
REQ-024 reset mid-access SHALL drop mem_req at that edge; a later mem_ack for the aborted access SHALL be ignored per REQ-020.

Configuration
REQ-025 Macro MEM_ARBITER_TIMEOUT_EN SHALL compile in a watchdog; without it bus_error is tied 0 and DATA/FETCH wait indefinitely.
REQ-026 With it: counter clears on entering DATA/FETCH, increments each cycle without mem_ack; on reaching TIMEOUT_CYCLES, bus_error=1 one cycle, mem_req drops, state IDLE, data_done unchanged (access retried); mem_ack in the same cycle wins over timeout.

Structure
REQ-027 Shared package mem_arb_pkg SHALL hold the state encoding (IDLE=0, DATA=1, FETCH=2) and request-type constants (REQ_LOAD=0, REQ_STORE=1).
REQ-028 Watchdog SHALL be a sub-module mem_arb_timer (counter, clear, enable, expired), instantiated only under MEM_ARBITER_TIMEOUT_EN.

Verification
REQ-029 Fetch only: fetch_request=1, fetch_addr=0x2000, mem_ack 2 cycles after mem_req with rdata 0x00000013 -> mem_addr=0x2000, fetch_data_valid=1 and stall=0 in ack cycle, request_data=0x00000013.
REQ-030 Load then fetch: memory_request=1 type 0 addr 0x100, ack rdata 0xDEADBEEF -> memory_data_valid=1 with 0xDEADBEEF, then FETCH issued, load not reissued, stall=1 until fetch ack.
REQ-031 Store: type 1, addr 0x104, data 0x12345678, mask 4'b0011 -> mem_we=1, mem_wmask=0011, memory_data_valid stays 0, fetch follows.
REQ-032 Reset asserted in DATA cycle 2 -> mem_req=0 next cycle; stray mem_ack one cycle later produces no valid strobe.
REQ-033 Timeout (macro on, TIMEOUT_CYCLES=4), no mem_ack -> bus_error=1 for one cycle, mem_req drops, access reissued next cycle.
REQ-034 Ack coinciding with timeout count -> normal completion, bus_error=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the fetch/data memory-port arbiter: FSM state encoding
// and datapath request-type values.
package mem_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] FETCH = 2'd2;

    localparam logic REQ_LOAD  = 1'b0;
    localparam logic REQ_STORE = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// Watchdog counter for an outstanding memory-port request; expired pulses in
// the cycle the count of ack-less cycles reaches MAX_COUNT.
module mem_arb_timer #(
    parameter int MAX_COUNT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(MAX_COUNT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_COUNT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The current cycle is the MAX_COUNT-th one without an ack.
    assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one memory port, data first.
// Optional watchdog compiled in with `define MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_addr,
    input  logic        fetch_request,
    input  logic [31:0] memory_addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  write_mask,
    input  logic        memory_request,
    input  logic        memory_request_type,
    output logic        stall,
    output logic        fetch_data_valid,
    output logic        memory_data_valid,
    output logic [31:0] request_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        bus_error,
    output logic [1:0]  dbg_state
);

    // Handshake: mem_req stays high with address/data/mask/we stable until the
    // memory returns a one-cycle mem_ack; mem_rdata is only meaningful with it.

    logic [1:0] state;
    logic       data_done;
    logic       timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            data_done <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
            mem_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (memory_request && !data_done) begin
                        state     <= DATA;
                        mem_addr  <= memory_addr;
                        mem_wdata <= write_data;
                        mem_wmask <= write_mask;
                        mem_we    <= memory_request_type;
                    end else if (fetch_request) begin
                        state     <= FETCH;
                        mem_addr  <= fetch_addr;
                        mem_wdata <= '0;
                        mem_wmask <= '0;
                        mem_we    <= 1'b0;
                    end
                end
                DATA: begin
                    if (mem_ack) begin
                        state     <= IDLE;
                        data_done <= 1'b1;
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
                FETCH: begin
                    // Fetch completion means the datapath has moved on to a new instruction.
                    if (mem_ack) begin
                        state     <= IDLE;
                        data_done <= 1'b0;
                    end else if (timeout) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_req           = (state == DATA) || (state == FETCH);
    assign memory_data_valid = (state == DATA) && mem_ack && (mem_we == REQ_LOAD);
    assign fetch_data_valid  = (state == FETCH) && mem_ack;
    assign request_data      = (mem_req && mem_ack) ? mem_rdata : 32'h0;
    assign stall             = !fetch_data_valid;
    assign dbg_state         = state;

`ifdef MEM_ARBITER_TIMEOUT_EN
    logic entering;
    logic timer_expired;

    assign entering = (state == IDLE) &&
                      ((memory_request && !data_done) || fetch_request);

    mem_arb_timer #(
        .MAX_COUNT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (entering),
        .enable  (mem_req && !mem_ack),
        .expired (timer_expired)
    );

    assign timeout   = timer_expired;
    assign bus_error = timer_expired;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; timeout scenarios run when MEM_ARBITER_TIMEOUT_EN is defined.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fetch_addr = '0;
    logic        fetch_request = 1'b0;
    logic [31:0] memory_addr = '0;
    logic [31:0] write_data = '0;
    logic [3:0]  write_mask = '0;
    logic        memory_request = 1'b0;
    logic        memory_request_type = 1'b0;
    logic        stall;
    logic        fetch_data_valid;
    logic        memory_data_valid;
    logic [31:0] request_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        bus_error;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .fetch_addr          (fetch_addr),
        .fetch_request       (fetch_request),
        .memory_addr         (memory_addr),
        .write_data          (write_data),
        .write_mask          (write_mask),
        .memory_request      (memory_request),
        .memory_request_type (memory_request_type),
        .stall               (stall),
        .fetch_data_valid    (fetch_data_valid),
        .memory_data_valid   (memory_data_valid),
        .request_data        (request_data),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_wmask           (mem_wmask),
        .mem_we              (mem_we),
        .mem_req             (mem_req),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .bus_error           (bus_error),
        .dbg_state           (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_stall", 32'(stall), 32'd1);
        chk("rst_fdv", 32'(fetch_data_valid), 32'd0);
        chk("rst_mdv", 32'(memory_data_valid), 32'd0);
        chk("rst_rdata", request_data, 32'h0);
        chk("rst_bus_error", 32'(bus_error), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);

        // Fetch only
        reset = 1'b0;
        fetch_request = 1'b1;
        fetch_addr = 32'h2000;
        #1;
        chk("f_idle_stall", 32'(stall), 32'd1);
        chk("f_idle_req", 32'(mem_req), 32'd0);
        tick();
        chk("f_req1", 32'(mem_req), 32'd1);
        chk("f_addr", mem_addr, 32'h2000);
        chk("f_we", 32'(mem_we), 32'd0);
        chk("f_wmask", 32'(mem_wmask), 32'd0);
        chk("f_stall1", 32'(stall), 32'd1);
        chk("f_noack_rdata", request_data, 32'h0);
        tick();
        chk("f_req2", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_0013;
        fetch_request = 1'b0;
        #1;
        chk("f_ack_fdv", 32'(fetch_data_valid), 32'd1);
        chk("f_ack_stall", 32'(stall), 32'd0);
        chk("f_ack_rdata", request_data, 32'h0000_0013);
        chk("f_ack_mdv", 32'(memory_data_valid), 32'd0);
        tick();
        mem_ack = 1'b0;
        mem_rdata = '0;
        #1;
        chk("f_done_req", 32'(mem_req), 32'd0);
        chk("f_done_fdv", 32'(fetch_data_valid), 32'd0);
        chk("f_done_stall", 32'(stall), 32'd1);

        // Load then fetch, data first
        memory_request = 1'b1;
        memory_request_type = 1'b0;
        memory_addr = 32'h100;
        fetch_request = 1'b1;
        fetch_addr = 32'h2004;
        tick();
        chk("l_state", 32'(dbg_state), 32'd1);
        chk("l_addr", mem_addr, 32'h100);
        chk("l_we", 32'(mem_we), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("l_ack_mdv", 32'(memory_data_valid), 32'd1);
        chk("l_ack_rdata", request_data, 32'hDEAD_BEEF);
        chk("l_ack_stall", 32'(stall), 32'd1);
        chk("l_ack_fdv", 32'(fetch_data_valid), 32'd0);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("l_idle_req", 32'(mem_req), 32'd0);
        chk("l_idle_mdv", 32'(memory_data_valid), 32'd0);
        tick();
        chk("lf_state", 32'(dbg_state), 32'd2);
        chk("lf_addr_not_reissued", mem_addr, 32'h2004);
        chk("lf_stall1", 32'(stall), 32'd1);
        tick();
        chk("lf_stall2", 32'(stall), 32'd1);
        mem_ack = 1'b1;
        mem_rdata = 32'h0010_0093;
        memory_request = 1'b0;
        fetch_request = 1'b0;
        #1;
        chk("lf_ack_fdv", 32'(fetch_data_valid), 32'd1);
        chk("lf_ack_stall", 32'(stall), 32'd0);
        chk("lf_ack_rdata", request_data, 32'h0010_0093);
        tick();
        mem_ack = 1'b0;

        // Stray ack while idle is ignored
        mem_ack = 1'b1;
        mem_rdata = 32'h5555_5555;
        #1;
        chk("stray_fdv", 32'(fetch_data_valid), 32'd0);
        chk("stray_mdv", 32'(memory_data_valid), 32'd0);
        chk("stray_rdata", request_data, 32'h0);
        tick();
        chk("stray_state", 32'(dbg_state), 32'd0);
        chk("stray_req", 32'(mem_req), 32'd0);
        mem_ack = 1'b0;

        // Store then fetch
        memory_request = 1'b1;
        memory_request_type = 1'b1;
        memory_addr = 32'h104;
        write_data = 32'h1234_5678;
        write_mask = 4'b0011;
        fetch_request = 1'b1;
        fetch_addr = 32'h2008;
        tick();
        chk("s_addr", mem_addr, 32'h104);
        chk("s_we", 32'(mem_we), 32'd1);
        chk("s_wmask", 32'(mem_wmask), 32'h3);
        chk("s_wdata", mem_wdata, 32'h1234_5678);
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("s_ack_mdv", 32'(memory_data_valid), 32'd0);
        chk("s_ack_stall", 32'(stall), 32'd1);
        tick();
        mem_ack = 1'b0;
        tick();
        chk("sf_state", 32'(dbg_state), 32'd2);
        chk("sf_we", 32'(mem_we), 32'd0);
        chk("sf_wmask", 32'(mem_wmask), 32'd0);
        chk("sf_addr", mem_addr, 32'h2008);
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_0000;
        memory_request = 1'b0;
        fetch_request = 1'b0;
        #1;
        chk("sf_ack_fdv", 32'(fetch_data_valid), 32'd1);
        tick();
        mem_ack = 1'b0;

        // Reset during the second DATA cycle aborts the access
        memory_request = 1'b1;
        memory_request_type = 1'b0;
        memory_addr = 32'h200;
        tick();
        chk("r_req1", 32'(mem_req), 32'd1);
        tick();
        chk("r_req2", 32'(mem_req), 32'd1);
        reset = 1'b1;
        memory_request = 1'b0;
        tick();
        chk("r_req_dropped", 32'(mem_req), 32'd0);
        chk("r_state", 32'(dbg_state), 32'd0);
        chk("r_addr_cleared", mem_addr, 32'h0);
        reset = 1'b0;
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'h7777_7777;
        #1;
        chk("r_stray_mdv", 32'(memory_data_valid), 32'd0);
        chk("r_stray_fdv", 32'(fetch_data_valid), 32'd0);
        chk("r_stray_rdata", request_data, 32'h0);
        tick();
        mem_ack = 1'b0;
        chk("r_stray_state", 32'(dbg_state), 32'd0);

`ifdef MEM_ARBITER_TIMEOUT_EN
        // Timeout with no ack, then retry completing on the timeout cycle
        memory_request = 1'b1;
        memory_request_type = 1'b0;
        memory_addr = 32'h300;
        tick();
        chk("t_c1_err", 32'(bus_error), 32'd0);
        tick();
        chk("t_c2_err", 32'(bus_error), 32'd0);
        tick();
        chk("t_c3_err", 32'(bus_error), 32'd0);
        tick();
        chk("t_c4_err", 32'(bus_error), 32'd1);
        chk("t_c4_req", 32'(mem_req), 32'd1);
        tick();
        chk("t_drop_err", 32'(bus_error), 32'd0);
        chk("t_drop_req", 32'(mem_req), 32'd0);
        tick();
        chk("t_retry_req", 32'(mem_req), 32'd1);
        chk("t_retry_addr", mem_addr, 32'h300);
        tick();
        tick();
        tick();
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_00A5;
        #1;
        chk("t_ack_err", 32'(bus_error), 32'd0);
        chk("t_ack_mdv", 32'(memory_data_valid), 32'd1);
        chk("t_ack_rdata", request_data, 32'h0000_00A5);
        memory_request = 1'b0;
        tick();
        mem_ack = 1'b0;
        #1;
        chk("t_end_err", 32'(bus_error), 32'd0);
        chk("t_end_state", 32'(dbg_state), 32'd0);
`else
        // Without the watchdog a data access waits indefinitely
        memory_request = 1'b1;
        memory_request_type = 1'b0;
        memory_addr = 32'h300;
        for (int i = 0; i < 8; i++) tick();
        chk("nt_req_held", 32'(mem_req), 32'd1);
        chk("nt_err", 32'(bus_error), 32'd0);
        mem_ack = 1'b1;
        mem_rdata = 32'h0000_00A5;
        memory_request = 1'b0;
        #1;
        chk("nt_ack_mdv", 32'(memory_data_valid), 32'd1);
        tick();
        mem_ack = 1'b0;
        #1;
        chk("nt_end_state", 32'(dbg_state), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
